// File: rtl/pq_cmd_sequencer.sv
// Command front-end for the pipelined-heap priority queue: buffers client commands, issues them
// one at a time to the heap and returns one response each. Define PQ_CMD_SEQ_STATS_EN for counters.
module pq_cmd_sequencer #(
  parameter int unsigned         CmdDepth = 4,
  parameter int unsigned         IssueGap = 2,
  parameter int unsigned         KvWidth  = 16,
  parameter logic [KvWidth-1:0]  KvEmpty  = '1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [1:0]                  req_op_i,
  input  logic [KvWidth-1:0]          req_kv_i,
  output logic                        resp_valid_o,
  input  logic                        resp_ready_i,
  output logic [KvWidth-1:0]          resp_kv_o,
  output logic                        resp_err_o,
  output logic                        pq_enq_o,
  output logic                        pq_deq_o,
  output logic [KvWidth-1:0]          pq_kvi_o,
  input  logic [KvWidth-1:0]          pq_kvo_i,
  input  logic                        pq_full_i,
  input  logic                        pq_empty_i,
  input  logic                        pq_busy_i,
  output logic [$clog2(CmdDepth):0]   cmd_count_o
`ifdef PQ_CMD_SEQ_STATS_EN
  ,
  output logic [15:0]                 stat_issued_o,
  output logic [15:0]                 stat_rejected_o,
  output logic [15:0]                 stat_maxocc_o
`endif
);

  localparam int unsigned PtrW    = $clog2(CmdDepth);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned GapW    = (IssueGap > 1) ? $clog2(IssueGap) : 1;
  localparam int unsigned GapLast = (IssueGap > 0) ? IssueGap - 1 : 0;

  localparam logic [1:0] OpNop  = 2'b00;
  localparam logic [1:0] OpEnq  = 2'b01;
  localparam logic [1:0] OpDeq  = 2'b10;
  localparam logic [1:0] OpRepl = 2'b11;

  typedef enum logic [2:0] {StIdle, StIssue, StGap, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_mem [CmdDepth];
  logic [KvWidth-1:0]  kv_mem [CmdDepth];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q;
  logic                fifo_full, fifo_empty, push, pop;
  logic [1:0]          head_op;
  logic [KvWidth-1:0]  head_kv;
  logic [GapW-1:0]     gap_cnt_q, gap_cnt_d;
  logic                pq_enq_q, pq_enq_d, pq_deq_q, pq_deq_d;
  logic [KvWidth-1:0]  pq_kvi_q, pq_kvi_d;
  logic [KvWidth-1:0]  resp_kv_q, resp_kv_d;
  logic                resp_err_q, resp_err_d;

  assign fifo_full   = (count_q == CntW'(CmdDepth));
  assign fifo_empty  = (count_q == '0);
  assign req_ready_o = rst_ni & ~fifo_full;
  assign push        = req_valid_i & req_ready_o;
  assign head_op     = op_mem[rd_ptr_q];
  assign head_kv     = kv_mem[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push) begin
      op_mem[wr_ptr_q] <= req_op_i;
      kv_mem[wr_ptr_q] <= req_kv_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    pq_enq_d   = 1'b0;
    pq_deq_d   = 1'b0;
    pq_kvi_d   = pq_kvi_q;
    resp_kv_d  = resp_kv_q;
    resp_err_d = resp_err_q;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Heap status is only trusted here, where the heap is known to be idle.
        if (!fifo_empty && !pq_busy_i) begin
          pop        = 1'b1;
          resp_err_d = 1'b0;
          resp_kv_d  = KvEmpty;
          unique case (head_op)
            OpNop: state_d = StResp;
            OpEnq: begin
              if (pq_full_i) begin
                resp_err_d = 1'b1;
                state_d    = StResp;
              end else begin
                pq_enq_d = 1'b1;
                pq_kvi_d = head_kv;
                state_d  = StIssue;
              end
            end
            OpDeq: begin
              if (pq_empty_i) begin
                resp_err_d = 1'b1;
                state_d    = StResp;
              end else begin
                pq_deq_d  = 1'b1;
                pq_kvi_d  = KvEmpty;
                resp_kv_d = pq_kvo_i;
                state_d   = StIssue;
              end
            end
            OpRepl: begin
              if (pq_empty_i) begin
                resp_err_d = 1'b1;
                state_d    = StResp;
              end else begin
                pq_enq_d  = 1'b1;
                pq_deq_d  = 1'b1;
                pq_kvi_d  = head_kv;
                resp_kv_d = pq_kvo_i;
                state_d   = StIssue;
              end
            end
            default: state_d = StResp;
          endcase
        end
      end
      StIssue: begin
        gap_cnt_d = '0;
        state_d   = (IssueGap == 0) ? StWait : StGap;
      end
      StGap: begin
        // The heap's busy flag lags the strobe, so it is ignored for these cycles.
        if (gap_cnt_q == GapW'(GapLast)) state_d = StWait;
        else gap_cnt_d = gap_cnt_q + 1'b1;
      end
      StWait: begin
        if (!pq_busy_i) state_d = StResp;
      end
      StResp: begin
        if (resp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      gap_cnt_q  <= '0;
      pq_enq_q   <= 1'b0;
      pq_deq_q   <= 1'b0;
      pq_kvi_q   <= KvEmpty;
      resp_kv_q  <= KvEmpty;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      pq_enq_q   <= pq_enq_d;
      pq_deq_q   <= pq_deq_d;
      pq_kvi_q   <= pq_kvi_d;
      resp_kv_q  <= resp_kv_d;
      resp_err_q <= resp_err_d;
    end
  end

  assign resp_valid_o = (state_q == StResp);
  assign resp_kv_o    = resp_kv_q;
  assign resp_err_o   = resp_err_q;
  assign pq_enq_o     = pq_enq_q;
  assign pq_deq_o     = pq_deq_q;
  assign pq_kvi_o     = pq_kvi_q;
  assign cmd_count_o  = count_q;

`ifdef PQ_CMD_SEQ_STATS_EN
  logic [15:0] stat_issued_q, stat_rejected_q, stat_maxocc_q;
  logic        reject_now;

  assign reject_now = (state_q == StIdle) && (state_d == StResp) && resp_err_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stat_issued_q   <= '0;
      stat_rejected_q <= '0;
      stat_maxocc_q   <= '0;
    end else begin
      if ((pq_enq_d || pq_deq_d) && (stat_issued_q != 16'hFFFF)) begin
        stat_issued_q <= stat_issued_q + 16'd1;
      end
      if (reject_now && (stat_rejected_q != 16'hFFFF)) begin
        stat_rejected_q <= stat_rejected_q + 16'd1;
      end
      if (16'(count_q) > stat_maxocc_q) stat_maxocc_q <= 16'(count_q);
    end
  end

  assign stat_issued_o   = stat_issued_q;
  assign stat_rejected_o = stat_rejected_q;
  assign stat_maxocc_o   = stat_maxocc_q;
`endif

endmodule

// File: tb/tb_pq_cmd_sequencer.sv
// Scoreboard bench for pq_cmd_sequencer: a sorted-queue heap model answers strobes, a reference
// model predicts strobes and responses per accepted command, monitors compare as the DUT presents.
module tb_pq_cmd_sequencer;

  localparam int unsigned CmdDepth = 4;
  localparam int unsigned IssueGap = 2;
  localparam int unsigned HeapCap  = 6;
  localparam logic [15:0] KvEmpty  = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [15:0] req_kv = 16'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [15:0] resp_kv;
  logic        resp_err;
  logic        pq_enq, pq_deq;
  logic [15:0] pq_kvi;
  logic [15:0] pq_kvo = KvEmpty;
  logic        pq_full = 1'b0, pq_empty = 1'b1, pq_busy = 1'b0;
  logic [2:0]  cmd_count;

  pq_cmd_sequencer #(
    .CmdDepth (CmdDepth),
    .IssueGap (IssueGap),
    .KvWidth  (16),
    .KvEmpty  (KvEmpty)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_op_i     (req_op),
    .req_kv_i     (req_kv),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_kv_o    (resp_kv),
    .resp_err_o   (resp_err),
    .pq_enq_o     (pq_enq),
    .pq_deq_o     (pq_deq),
    .pq_kvi_o     (pq_kvi),
    .pq_kvo_i     (pq_kvo),
    .pq_full_i    (pq_full),
    .pq_empty_i   (pq_empty),
    .pq_busy_i    (pq_busy),
    .cmd_count_o  (cmd_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic err; logic [15:0] kv;} resp_t;
  typedef struct packed {logic enq; logic deq; logic [15:0] kv;} strobe_t;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  resp_t       exp_resp[$];
  strobe_t     exp_strobe[$];
  logic [15:0] ref_heap[$];
  logic [15:0] heap[$];
  logic [15:0] snap[$];
  int          rr_mode = 0;  // 0: always ready, 1: random, 2: hold low
  int          n_strobes = 0;
  int          busy_cnt = 0;
  int unsigned strobe_edge = 0, accept_edge = 0, resp_rise_edge = 0;
  logic        prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference model: what the heap-fronted queue must answer, in command order.
  task automatic model_accept(input logic [1:0] op, input logic [15:0] kv);
    resp_t   r;
    strobe_t s;
    r.err = 1'b0;
    r.kv  = KvEmpty;
    case (op)
      2'b01: begin
        if (ref_heap.size() == HeapCap) r.err = 1'b1;
        else begin
          ref_heap.push_back(kv);
          ref_heap.sort();
          s = {1'b1, 1'b0, kv};
          exp_strobe.push_back(s);
        end
      end
      2'b10: begin
        if (ref_heap.size() == 0) r.err = 1'b1;
        else begin
          r.kv = ref_heap.pop_front();
          s = {1'b0, 1'b1, KvEmpty};
          exp_strobe.push_back(s);
        end
      end
      2'b11: begin
        if (ref_heap.size() == 0) r.err = 1'b1;
        else begin
          r.kv = ref_heap.pop_front();
          ref_heap.push_back(kv);
          ref_heap.sort();
          s = {1'b1, 1'b1, kv};
          exp_strobe.push_back(s);
        end
      end
      default: ;
    endcase
    exp_resp.push_back(r);
  endtask

  // Heap emulator; its busy flag rises only after the strobe, mimicking a registered start.
  always @(negedge clk) begin : emu
    strobe_t s, e;
    if (!rst_n) begin
      heap.delete();
      busy_cnt = 0;
    end else begin
      if (busy_cnt > 0) busy_cnt--;
      if (pq_enq === 1'b1 || pq_deq === 1'b1) begin
        s = {pq_enq, pq_deq, pq_kvi};
        n_strobes++;
        strobe_edge = cyc;
        if (exp_strobe.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got %h, required none", s);
        end else begin
          e = exp_strobe.pop_front();
          check("strobe", 32'(s), 32'(e));
        end
        if (pq_deq) begin
          if (heap.size() == 0) begin
            checks++; errors++;
            $display("FAIL heap_underflow: got deq on empty heap, required none");
          end else void'(heap.pop_front());
        end
        if (pq_enq) begin
          if (heap.size() >= HeapCap) begin
            checks++; errors++;
            $display("FAIL heap_overflow: got enq on full heap, required none");
          end else begin
            heap.push_back(pq_kvi);
            heap.sort();
          end
        end
        busy_cnt = 1 + int'($urandom_range(0, 3));
      end
    end
    pq_busy  = (busy_cnt > 0);
    pq_kvo   = (heap.size() > 0) ? heap[0] : KvEmpty;
    pq_empty = (heap.size() == 0);
    pq_full  = (heap.size() == HeapCap);
  end

  // Response monitor; also owns resp_ready.
  always @(negedge clk) begin : mon
    resp_t a, e;
    if (rst_n) begin
      if (resp_valid === 1'b1) begin
        if (!prev_valid) resp_rise_edge = cyc;
        a = {resp_err, resp_kv};
        if (exp_resp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got %h, required none", a);
        end else begin
          e = exp_resp[0];
          check("resp", 32'(a), 32'(e));
        end
      end
      case (rr_mode)
        0:       resp_ready = 1'b1;
        1:       resp_ready = ($urandom_range(0, 2) != 0);
        default: resp_ready = 1'b0;
      endcase
      if (resp_valid === 1'b1 && resp_ready && exp_resp.size() > 0) void'(exp_resp.pop_front());
    end else begin
      resp_ready = 1'b0;
    end
    prev_valid = rst_n && (resp_valid === 1'b1);
  end

  task automatic send(input logic [1:0] op, input logic [15:0] kv);
    int t = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_kv    = kv;
    while (req_ready !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: req_ready=%b, required 1", req_ready);
    end else begin
      model_accept(op, kv);
      accept_edge = cyc + 1;
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_resp.size() != 0 || exp_strobe.size() != 0 || cmd_count != 0 ||
            resp_valid !== 1'b0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d responses pending, required 0", exp_resp.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 0);
    check({tag, "_resp_kv"}, 32'(resp_kv), 32'(KvEmpty));
    check({tag, "_resp_err"}, 32'(resp_err), 0);
    check({tag, "_pq_enq"}, 32'(pq_enq), 0);
    check({tag, "_pq_deq"}, 32'(pq_deq), 0);
    check({tag, "_pq_kvi"}, 32'(pq_kvi), 32'(KvEmpty));
    check({tag, "_cmd_count"}, 32'(cmd_count), 0);
  endtask

  initial begin
    int s0;
    int t;
    int op_sel;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("req_ready_after_reset", 32'(req_ready), 1);

    // Single ENQ: strobe latency, strobe count, response latency floor.
    s0 = n_strobes;
    send(2'b01, 16'h0005);
    wait_drain();
    check("enq_strobe_count", n_strobes - s0, 1);
    check("enq_strobe_latency", strobe_edge + 1 - accept_edge, 2);
    check("enq_resp_after_gap", 32'((resp_rise_edge - strobe_edge) >= 1 + IssueGap), 1);

    send(2'b00, 16'h1234);
    wait_drain();
    check("nop_resp_latency", resp_rise_edge + 1 - accept_edge, 2);

    // Ordering: heap holds {5}; drain it, then 9,3,7 come back sorted.
    send(2'b10, 16'h0);
    send(2'b01, 16'd9);
    send(2'b01, 16'd3);
    send(2'b01, 16'd7);
    repeat (3) send(2'b10, 16'h0);
    wait_drain();
    s0 = n_strobes;
    send(2'b10, 16'h0);
    wait_drain();
    check("deq_empty_no_strobe", n_strobes - s0, 0);

    // Full heap rejects ENQ and leaves contents alone.
    for (int i = 0; ref_heap.size() < HeapCap; i++) send(2'b01, 16'(100 + i));
    wait_drain();
    snap = ref_heap;
    s0 = n_strobes;
    send(2'b01, 16'd1);
    wait_drain();
    check("full_enq_no_strobe", n_strobes - s0, 0);
    check("full_heap_size", heap.size(), snap.size());
    for (int i = 0; i < snap.size() && i < heap.size(); i++) check("full_heap_entry", heap[i], snap[i]);
    while (ref_heap.size() > 0) send(2'b10, 16'h0);
    wait_drain();

    // Backpressure: first response held, FIFO fills, a sixth command waits.
    rr_mode = 2;
    s0 = n_strobes;
    send(2'b01, 16'd20);
    send(2'b01, 16'd21);
    send(2'b10, 16'h0);
    send(2'b00, 16'h0);
    send(2'b01, 16'd22);
    check("bp_cmd_count_full", 32'(cmd_count), CmdDepth);
    check("bp_req_ready_low", 32'(req_ready), 0);
    fork
      send(2'b10, 16'h0);
      begin
        repeat (20) @(negedge clk);
        check("bp_hold_strobes", n_strobes - s0, 1);
        check("bp_hold_count", 32'(cmd_count), CmdDepth);
        rr_mode = 0;
      end
    join
    wait_drain();
    while (ref_heap.size() > 0) send(2'b10, 16'h0);
    wait_drain();

    // REPL on {4,8} returns 4 and leaves {6,8}.
    send(2'b01, 16'd4);
    send(2'b01, 16'd8);
    send(2'b11, 16'd6);
    send(2'b10, 16'h0);
    send(2'b10, 16'h0);
    wait_drain();

    // Reset while the command sits in GAP: no response, outputs return to reset values.
    s0 = n_strobes;
    send(2'b01, 16'h0033);
    t = 0;
    while (n_strobes == s0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("gap_test_strobe_seen", n_strobes - s0, 1);
    @(negedge clk);
    rst_n = 1'b0;
    exp_resp.delete();
    exp_strobe.delete();
    ref_heap.delete();
    @(negedge clk);
    check_reset_outputs("midop_reset");
    rst_n = 1'b1;
    s0 = n_strobes;
    repeat (20) @(negedge clk);
    check("midop_no_strobe", n_strobes - s0, 0);
    check("midop_req_ready", 32'(req_ready), 1);

    // Randomised traffic with random response backpressure.
    rr_mode = 1;
    for (int i = 0; i < 300; i++) begin
      op_sel = int'($urandom_range(0, 9));
      if (op_sel == 0)      send(2'b00, 16'($urandom_range(0, 200)));
      else if (op_sel < 5)  send(2'b01, 16'($urandom_range(0, 200)));
      else if (op_sel < 8)  send(2'b10, 16'h0);
      else                  send(2'b11, 16'($urandom_range(0, 200)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rr_mode = 0;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog expired");
  end

endmodule
